// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants and state encoding for the
// iterative BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

  localparam int DIG_W       = 4;
  localparam int MAX_DIGIT   = 9;
  localparam int CORR_THRESH = 8;
  localparam int CORR_AMT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic digit_gt9(
    input logic [DIG_W-1:0] d
  );
    return d > DIG_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_sub3_if_gte8.sv
// Reverse double-dabble digit cell: subtract 3
// from a BCD digit that has reached 8 after a shift.
module sub3_if_gte8
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [DIG_W-1:0] i_d,
  output logic [DIG_W-1:0] o_d
);

  logic w_gte;

  assign w_gte = i_d >= DIG_W'(CORR_THRESH);
  assign o_d   = w_gte ? i_d - DIG_W'(CORR_AMT)
                       : i_d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter using reverse
// double dabble, one shift per clock, start/done handshake.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int BCD_W = DIG_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  function automatic logic has_bad_digit(
    input logic [BCD_W-1:0] v
  );
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | digit_gt9(v[i*DIG_W +: DIG_W]);
    end
    return bad;
  endfunction

  state_t r_state;
  state_t w_next;

  logic [BCD_W-1:0] r_bcd;
  logic [BIN_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_bin;
  logic             r_err;

  logic [BCD_W-1:0] w_bcd_sh;
  logic [BCD_W-1:0] w_bcd_fix;
  logic [BIN_W-1:0] w_acc_sh;
  logic             w_bad;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;

  // Bit leaving the BCD side enters the binary MSB.
  assign w_bcd_sh = {1'b0, r_bcd[BCD_W-1:1]};
  assign w_acc_sh = {r_bcd[0], r_acc[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    sub3_if_gte8 u_corr (
      .i_d (w_bcd_sh[g*DIG_W +: DIG_W]),
      .o_d (w_bcd_fix[g*DIG_W +: DIG_W])
    );
  end

  assign w_bad    = has_bad_digit(bcd_in);
  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_last   = w_shift && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = w_bad ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_bin <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_bcd <= bcd_in;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= w_bad;
      if (w_bad) begin
        r_bin <= '0;
      end
    end else if (w_shift) begin
      r_bcd <= w_bcd_fix;
      r_acc <= w_acc_sh;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_bin <= w_acc_sh;
      end
    end
  end

  assign bin_out = r_bin;
  assign err     = r_err;
  assign done    = (r_state == ST_DONE);
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq
// against a plain-arithmetic reference model.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int LIMIT  = 40;

  logic              clk;
  logic              rst;
  logic              start;
  logic [4*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]  bin_out;
  logic              done;
  logic              busy;
  logic              err;

  int n_checks;
  int n_errors;

  bcd_to_bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [11:0] b);
    bit e;
    e = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (((b >> (4 * i)) & 12'hF) > 9) e = 1;
    end
    return e;
  endfunction

  function automatic int model_val(input logic [11:0] b);
    int v;
    if (model_err(b)) return 0;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'((b >> (4 * i)) & 12'hF);
    end
    return v % (1 << BIN_W);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for done; returns the number of edges taken.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < LIMIT) begin
      if (!busy) begin
        chk("busy_during", 32'(busy), 32'd1);
      end
      tick();
      lat++;
    end
  endtask

  task automatic finish_conv(
    input string       tag,
    input logic [11:0] b
  );
    int lat;
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), model_err(b) ? 32'd0 : 32'(BIN_W));
    chk({tag, "_bin"}, 32'(bin_out), 32'(model_val(b)));
    chk({tag, "_err"}, 32'(err), 32'(model_err(b)));
    chk({tag, "_busyD"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done1"}, 32'(done), 32'd0);
  endtask

  task automatic run_conv(
    input string       tag,
    input logic [11:0] b
  );
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    tick();
    start  = 1'b0;
    bcd_in = 12'($urandom);
    finish_conv(tag, b);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [11:0] rb;
  int          lat;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bcd_in   = '0;
    tick();
    tick();
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_conv("c999", 12'h999);
    run_conv("c000", 12'h000);
    run_conv("c128", 12'h128);
    run_conv("c015", 12'h015);
    run_conv("c1A5", 12'h1A5);
    run_conv("c042", 12'h042);

    // start held high: back-to-back conversions
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h500;
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_done(lat);
      chk("hold_lat", 32'(lat), 32'(BIN_W));
      chk("hold_bin", 32'(bin_out), 32'd500);
      tick();
      chk("hold_done0", 32'(done), 32'd0);
      chk("hold_idle", 32'(busy), 32'd0);
      tick();
      chk("hold_reacc", 32'(busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    tick();
    tick();

    // start during SHIFT is ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h777;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h111;
    tick();
    start  = 1'b0;
    bcd_in = 12'h222;
    wait_done(lat);
    chk("ign_lat", 32'(lat + 4), 32'(BIN_W));
    chk("ign_bin", 32'(bin_out), 32'd777);
    tick();
    chk("ign_done1", 32'(done), 32'd0);

    // reset mid-conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h999;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mrst_bin", 32'(bin_out), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) chk("mrst_nodone", 32'(done), 32'd0);
    end
    run_conv("c321", 12'h321);

    // randomized operands, some with illegal digits
    for (int n = 0; n < 40; n++) begin
      rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) begin
        rb[4 * $urandom_range(0, DIGITS - 1) +: 4] =
          4'($urandom_range(10, 15));
      end
      run_conv("rnd", rb);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Iterative BCD-to-binary converter. It is the reverse direction of the team's double-dabble binary-to-BCD path.
- Uses reverse double dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is ≥ 8.
- Sits between BCD keypad/display entry logic and the binary arithmetic datapath.
- Uses a start/done handshake with a fixed, data-independent latency.

Parameters:
- DIGITS, 3, number of packed BCD input digits.
- BIN_W, 10, binary output width. Must be ≥ ceil(log2(10^DIGITS)). Also sets the number of shift cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion. Sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD operand. Digit 0 is in bits [3:0]. Sampled on the accepting edge.
- bin_out  output  BIN_W  converted binary value. Registered and held until the next accepted start.
- done  output  1  one-cycle pulse: bin_out/err are valid and newly updated.
- busy  output  1  high whenever state ≠ IDLE.
- err  output  1  last accepted operand contained a digit > 9. Held until the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over all other inputs.
- Reset values: bin_out=0, done=0, busy=0, err=0. State goes to IDLE and the shift counter to 0.
- States:
  - IDLE: wait for start.
  - SHIFT: run the conversion.
  - DONE: one cycle, done=1.
- Working register: {bcd_reg[4*DIGITS-1:0], acc[BIN_W-1:0]}.
- IDLE & start & all digits ≤ 9 → SHIFT. On that edge: bcd_reg=bcd_in, acc=0, cnt=0, err cleared.
- IDLE & start & any digit > 9 → DONE. On that edge: err=1, bin_out=0, no shifts performed.
- SHIFT, every edge:
  - Shift {bcd_reg, acc} right by 1; bcd_reg LSB moves into acc MSB and bcd_reg MSB fills with 0.
  - Then each 4-bit digit of the shifted bcd_reg that is ≥ 8 has 3 subtracted, modulo 16. This is combinational within the same cycle.
  - cnt increments.
- SHIFT, edge where cnt = BIN_W-1 (i.e. the BIN_W-th shift): bin_out ← shifted acc, done ← 1, state → DONE.
- Latency: done rises exactly BIN_W edges after the start-sampling edge (10 for the defaults). For an invalid operand, done rises on the sampling edge itself.
- DONE → IDLE on the next edge; done returns to 0. done is never high for two consecutive cycles.
- start is ignored in SHIFT and DONE. No queuing. If start is held high, it is re-accepted on the first IDLE cycle, one cycle after the done pulse.
- bcd_in changes after acceptance have no effect.
- rst asserted mid-conversion: next edge forces the reset values. A partial result is never presented; done is not pulsed.
- Operands whose value needs more than BIN_W bits are a parameter misuse. Result is truncated to BIN_W bits and not flagged.

Decomposition:
- Shared package holds:
  - BCD digit width constant (4).
  - Max legal digit constant (9).
  - Correction threshold (8) and correction amount (3).
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- One natural sub-module: sub3_if_gte8.
  - Combinational 4-bit digit corrector: out = in ≥ 8 ? in−3 : in.
  - Instantiated DIGITS times via generate on the shifted register.
  - It is the inverse cell of the existing add-3-if-≥5 cell.
- Digit-validity check (> 9) is a small local function/assign; no separate module.

Test Plan:
- Reset, then bcd_in=12'h999, start for 1 cycle → busy=1 for 11 cycles (10 SHIFT + 1 DONE); done pulses 10 edges after acceptance; bin_out=10'd999 (11_1110_0111); err=0.
- bcd_in=12'h000, then 12'h128, then 12'h015, one at a time → bin_out=0, 128, 15 respectively; each done is exactly 1 cycle wide.
- bcd_in=12'h1A5 with start → done on the accepting edge, err=1, bin_out=0, busy high only during DONE. Next start with 12'h042 → err cleared, bin_out=42.
- start held high continuously with bcd_in=12'h500 → back-to-back conversions; each done is followed by exactly one IDLE cycle before re-acceptance; bin_out=500 each time.
- Start 12'h777; after 4 SHIFT cycles pulse start with 12'h111 and change bcd_in → ignored; result is 777.
- Start 12'h999; assert rst on the 5th SHIFT cycle → all outputs 0 next cycle, no done pulse. A fresh start with 12'h321 yields 321 with full latency.
